// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared packet width and field layout for decode packing and issuer unpacking
package issue_queue_pkg;
  localparam int ISSUE_Q_WIDTH = 123;
  localparam int RD_ID_LSB     = 0;
  localparam int RS2_ID_LSB    = 5;
  localparam int RS1_ID_LSB    = 10;
  localparam int CUR_PC_LSB    = 15;
  localparam int NEXT_PC_LSB   = 47;
  localparam int TAKEN_LSB     = 79;
  localparam int IMM_LSB       = 80;
  localparam int OPERAND_LSB   = 112;
  localparam int OPERATOR_LSB  = 116;
  localparam int FUNCTION_LSB  = 120;
  localparam int ID_W          = 5;
  localparam int PC_W          = 32;
  localparam int IMM_W         = 32;
  localparam int OPERAND_W     = 4;
  localparam int OPERATOR_W    = 4;
  localparam int FUNCTION_W    = 3;
endpackage

// File: rtl/issue_queue_mem.sv
// issue_queue_mem: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port, no reset
//   clk, we, waddr, wdata : write port
//   raddr, rdata          : combinational read port
module issue_queue_mem #(
  parameter int WIDTH = 123,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/issue_queue.sv
// issue_queue: first-word-fall-through FIFO between decode and the issuer
//   CLK, RSTN (sync, active-low), issue_q_flush : clock, reset, discard all entries
//   issue_q_wen/wdata/wok/almost_full           : decode push side
//   issue_q_ren/rok/rdata                       : issuer pop side (rdata is zero when empty)
//   issue_q_count                               : occupancy
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int ISSUE_Q_WIDTH      = issue_queue_pkg::ISSUE_Q_WIDTH,
  parameter int ISSUE_Q_DEPTH      = 8,
  parameter int ALMOST_FULL_TH     = 6,
  parameter int ISSUE_Q_DEPTH_LOG2 = $clog2(ISSUE_Q_DEPTH)
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          issue_q_flush,
  input  logic                          issue_q_wen,
  input  logic [ISSUE_Q_WIDTH-1:0]      issue_q_wdata,
  output logic                          issue_q_wok,
  output logic                          issue_q_almost_full,
  input  logic                          issue_q_ren,
  output logic                          issue_q_rok,
  output logic [ISSUE_Q_WIDTH-1:0]      issue_q_rdata,
  output logic [ISSUE_Q_DEPTH_LOG2:0]   issue_q_count
);
  localparam int PW = ISSUE_Q_DEPTH_LOG2 + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [ISSUE_Q_WIDTH-1:0] head;
  logic push, pop;
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign issue_q_count       = wr_ptr - rd_ptr;
  assign issue_q_rok         = wr_ptr != rd_ptr;
  assign issue_q_wok         = issue_q_count != PW'(ISSUE_Q_DEPTH);
  assign issue_q_almost_full = issue_q_count >= PW'(ALMOST_FULL_TH);
  assign issue_q_rdata       = issue_q_rok ? head : '0;
  // Storage is never reset, so writes are suppressed while reset is held.
  assign push = RSTN & issue_q_wen & issue_q_wok & ~issue_q_flush;
  assign pop  = issue_q_ren & issue_q_rok & ~issue_q_flush;
  always_ff @(posedge CLK) begin
    if (!RSTN || issue_q_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  issue_queue_mem #(.WIDTH(ISSUE_Q_WIDTH), .DEPTH(ISSUE_Q_DEPTH), .AW(ISSUE_Q_DEPTH_LOG2)) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr[ISSUE_Q_DEPTH_LOG2-1:0]),
    .wdata (issue_q_wdata),
    .raddr (rd_ptr[ISSUE_Q_DEPTH_LOG2-1:0]),
    .rdata (head)
  );
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed and random stimulus against a queue-based reference model
module tb_issue_queue;
  localparam int W = 123;
  localparam int D = 8;
  localparam int TH = 6;
  logic CLK = 0, RSTN = 0, flush = 0, wen = 0, ren = 0;
  logic [W-1:0] wdata = '0;
  logic wok, afull, rok;
  logic [W-1:0] rdata;
  logic [3:0] count;
  int checks = 0, errors = 0;
  logic [W-1:0] q [$];
  always #5 CLK = ~CLK;
  issue_queue dut (
    .CLK                 (CLK),
    .RSTN                (RSTN),
    .issue_q_flush       (flush),
    .issue_q_wen         (wen),
    .issue_q_wdata       (wdata),
    .issue_q_wok         (wok),
    .issue_q_almost_full (afull),
    .issue_q_ren         (ren),
    .issue_q_rok         (rok),
    .issue_q_rdata       (rdata),
    .issue_q_count       (count)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 128'(count), 128'(n));
    chk({tag, ".rok"}, 128'(rok), 128'(n != 0));
    chk({tag, ".wok"}, 128'(wok), 128'(n < D));
    chk({tag, ".afull"}, 128'(afull), 128'(n >= TH));
    chk({tag, ".rdata"}, 128'(rdata), n != 0 ? 128'(q[0]) : 128'(0));
  endtask
  task automatic step(input string tag, input logic rn, input logic fl, input logic we,
                      input logic [W-1:0] wd, input logic re);
    bit do_push, do_pop;
    RSTN = rn; flush = fl; wen = we; wdata = wd; ren = re;
    @(posedge CLK);
    if (!rn || fl) q.delete();
    else begin
      do_push = we && q.size() < D;
      do_pop  = re && q.size() > 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(wd);
    end
    #1;
    check_all(tag);
  endtask
  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction
  initial begin
    step("rst0", 0, 0, 0, '0, 0);
    step("rst1", 0, 0, 0, '0, 0);
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, 1, W'(i), 0);
    chk("fill_full_cnt", 128'(count), 128'(8));
    chk("fill_head", 128'(rdata), 128'(1));
    step("fill_drop", 1, 0, 1, W'(16'hDEAD), 0);
    chk("drop_cnt", 128'(count), 128'(8));
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 128'(rdata), 128'(i));
      step("drain", 1, 0, i >= 3 && i <= 6, W'(i + 6), 1);
    end
    for (int i = 9; i <= 12; i++) begin
      chk("wrap_order", 128'(rdata), 128'(i));
      step("wrap", 1, 0, 0, '0, 1);
    end
    chk("wrap_empty", 128'(rok), 128'(0));
    step("sim_empty", 1, 0, 1, W'(8'h77), 1);
    chk("sim_empty_data", 128'(rdata), 128'(8'h77));
    for (int i = 0; i < 7; i++) step("refill", 1, 0, 1, W'(8'h30 + i), 0);
    step("sim_full", 1, 0, 1, W'(8'hEE), 1);
    chk("sim_full_cnt", 128'(count), 128'(7));
    step("flush_pre", 1, 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) step("fl_fill", 1, 0, 1, rnd(), 0);
    step("flush", 1, 1, 1, rnd(), 1);
    chk("flush_cnt", 128'(count), 128'(0));
    step("post_flush", 1, 0, 1, W'(8'hA5), 0);
    chk("post_flush_data", 128'(rdata), 128'(8'hA5));
    for (int i = 0; i < 3; i++) step("rs_fill", 1, 0, 1, rnd(), 0);
    step("mid_reset", 0, 0, 1, rnd(), 0);
    chk("mid_reset_cnt", 128'(count), 128'(0));
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 300) % 3;
      step("rand", $urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) < (bias == 0 ? 3 : 2),
           rnd(), $urandom_range(0, 3) < (bias == 1 ? 3 : 2));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
